// File: rtl/io_port_arbiter_pkg.sv
// Shared defaults and read-return tag type for the multi-slot IO cell.
package io_port_arbiter_pkg;

   localparam int NUM_PORTS     = 4;
   localparam int IO_DATA_WIDTH = 256;
   localparam int IO_ADDR_WIDTH = 16;
   localparam int IO_RD_LATENCY = 1;
   localparam int PORT_ID_WIDTH = $clog2(NUM_PORTS);

   typedef logic [PORT_ID_WIDTH-1:0] port_id_t;

   typedef struct packed {
      logic     valid;
      port_id_t id;
   } io_tag_t;

endpackage

// File: rtl/io_port_arbiter_rr.sv
// Combinational round-robin scan: first requester at or after ptr wins, wrapping to index 0.
// Zero latency; the pointer register is owned by the caller.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] winner,
   output logic           found
);

   logic           hi_hit, lo_hit;
   logic [IDW-1:0] hi_win, lo_win;

   // Descending scan so the last hit recorded is the lowest index in each half.
   always_comb begin
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      hi_win = '0;
      lo_win = '0;
      for (int p = N - 1; p >= 0; p--) begin
         if (req[p]) begin
            lo_hit = 1'b1;
            lo_win = IDW'(p);
            if (p >= int'(ptr)) begin
               hi_hit = 1'b1;
               hi_win = IDW'(p);
            end
         end
      end
      found  = hi_hit | lo_hit;
      winner = hi_hit ? hi_win : lo_win;
      grant  = found ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;
   end

endmodule

// File: rtl/io_port_arbiter.sv
// Round-robin share of one IO read bus and one IO write bus among NUM_PORTS slots.
// Writes issue 1 cycle after grant; read data returns IO_RD_LATENCY+2 cycles after grant; no response backpressure.
module io_port_arbiter #(
   parameter int NUM_PORTS     = io_port_arbiter_pkg::NUM_PORTS,
   parameter int IO_DATA_WIDTH = io_port_arbiter_pkg::IO_DATA_WIDTH,
   parameter int IO_ADDR_WIDTH = io_port_arbiter_pkg::IO_ADDR_WIDTH,
   parameter int IO_RD_LATENCY = io_port_arbiter_pkg::IO_RD_LATENCY,
   parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_PORTS-1:0]               req_valid,
   output logic [NUM_PORTS-1:0]               req_ready,
   input  logic [NUM_PORTS-1:0]               req_we,
   input  logic [NUM_PORTS*IO_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*IO_DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]               rsp_valid,
   output logic [IO_DATA_WIDTH-1:0]           rsp_rdata,
   output logic                               io_en_in,
   output logic [IO_ADDR_WIDTH-1:0]           io_addr_in,
   input  logic [IO_DATA_WIDTH-1:0]           io_data_in,
   output logic                               io_en_out,
   output logic [IO_ADDR_WIDTH-1:0]           io_addr_out,
   output logic [IO_DATA_WIDTH-1:0]           io_data_out,
   output logic                               idle
);
   import io_port_arbiter_pkg::io_tag_t;
   import io_port_arbiter_pkg::port_id_t;

   localparam int AW = IO_ADDR_WIDTH;
   localparam int DW = IO_DATA_WIDTH;

   logic [NUM_PORTS-1:0]     grant;
   logic [PORT_ID_WIDTH-1:0] winner, rr_ptr, nxt_ptr;
   logic                     found;
   logic                     sel_we;
   logic [AW-1:0]            sel_addr;
   logic [DW-1:0]            sel_wdata;
   io_tag_t                  rd_tag;
   io_tag_t                  tag_pipe [IO_RD_LATENCY];
   logic                     tag_busy;

   rr_arbiter #(.N(NUM_PORTS), .IDW(PORT_ID_WIDTH)) u_rr (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .grant  (grant),
      .winner (winner),
      .found  (found)
   );

   assign req_ready = grant;

   // Explicit wrap keeps the pointer inside 0..NUM_PORTS-1 for non-power-of-two counts.
   always_comb begin
      nxt_ptr = (winner == PORT_ID_WIDTH'(NUM_PORTS - 1)) ? '0 : winner + PORT_ID_WIDTH'(1);
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant[p]) begin
            sel_we    = req_we[p];
            sel_addr  = req_addr[p*AW +: AW];
            sel_wdata = req_wdata[p*DW +: DW];
         end
      end
   end

   always_comb begin
      tag_busy = 1'b0;
      for (int k = 0; k < IO_RD_LATENCY; k++) begin
         tag_busy = tag_busy | tag_pipe[k].valid;
      end
   end

   // rd_tag travels with io_en_in; the pipe then delays it so its last stage lines up with io_data_in.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= '0;
         io_en_in    <= 1'b0;
         io_addr_in  <= '0;
         io_en_out   <= 1'b0;
         io_addr_out <= '0;
         io_data_out <= '0;
         rd_tag      <= '0;
         for (int k = 0; k < IO_RD_LATENCY; k++) begin
            tag_pipe[k] <= '0;
         end
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         idle        <= 1'b1;
      end else begin
         io_en_in     <= found & ~sel_we;
         io_en_out    <= found & sel_we;
         rd_tag.valid <= found & ~sel_we;
         rd_tag.id    <= port_id_t'(winner);
         if (found) begin
            rr_ptr <= nxt_ptr;
            if (sel_we) begin
               io_addr_out <= sel_addr;
               io_data_out <= sel_wdata;
            end else begin
               io_addr_in  <= sel_addr;
            end
         end
         tag_pipe[0] <= rd_tag;
         for (int k = 1; k < IO_RD_LATENCY; k++) begin
            tag_pipe[k] <= tag_pipe[k-1];
         end
         rsp_valid <= '0;
         if (tag_pipe[IO_RD_LATENCY-1].valid) begin
            rsp_valid <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << tag_pipe[IO_RD_LATENCY-1].id;
            rsp_rdata <= io_data_in;
         end
         idle <= ~io_en_in & ~io_en_out & ~tag_busy & ~(|rsp_valid);
      end
   end

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed bench for io_port_arbiter: three instances (4 ports lat 1, 4 ports lat 3, 3 ports lat 1), read scoreboard.
module tb_io_port_arbiter;

   localparam int DW = 256;
   localparam int AW = 16;
   localparam int LAT [3] = '{1, 3, 1};

   typedef struct {
      int            port;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [3:0]      req_valid, req_we;
   logic [4*AW-1:0] req_addr;
   logic [4*DW-1:0] req_wdata;

   logic [3:0]    rdy   [3];
   logic [3:0]    rspv  [3];
   logic [DW-1:0] rdata [3];
   logic [DW-1:0] io_din[3];
   logic [DW-1:0] dout  [3];
   logic [AW-1:0] ain   [3];
   logic [AW-1:0] aout  [3];
   logic          en_in [3];
   logic          en_out[3];
   logic          idle_o[3];
   logic [2:0]    rdy_c, rspv_c;

   logic [DW-1:0] dl [3][4];
   exp_t          sb [$];
   logic [1:0]    sel;
   int            cyc, total, passed;

   io_port_arbiter #(.NUM_PORTS(4), .IO_RD_LATENCY(1)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]),
      .io_en_in(en_in[0]), .io_addr_in(ain[0]), .io_data_in(io_din[0]), .io_en_out(en_out[0]),
      .io_addr_out(aout[0]), .io_data_out(dout[0]), .idle(idle_o[0])
   );

   io_port_arbiter #(.NUM_PORTS(4), .IO_RD_LATENCY(3)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]),
      .io_en_in(en_in[1]), .io_addr_in(ain[1]), .io_data_in(io_din[1]), .io_en_out(en_out[1]),
      .io_addr_out(aout[1]), .io_data_out(dout[1]), .idle(idle_o[1])
   );

   io_port_arbiter #(.NUM_PORTS(3), .IO_RD_LATENCY(1)) dut_c (
      .clk(clk), .rst(rst), .req_valid(req_valid[2:0]), .req_ready(rdy_c), .req_we(req_we[2:0]),
      .req_addr(req_addr[3*AW-1:0]), .req_wdata(req_wdata[3*DW-1:0]), .rsp_valid(rspv_c),
      .rsp_rdata(rdata[2]), .io_en_in(en_in[2]), .io_addr_in(ain[2]), .io_data_in(io_din[2]),
      .io_en_out(en_out[2]), .io_addr_out(aout[2]), .io_data_out(dout[2]), .idle(idle_o[2])
   );

   assign rdy[2]  = {1'b0, rdy_c};
   assign rspv[2] = {1'b0, rspv_c};

   function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
      return {8{a ^ 16'hDEAD, ~a}};
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one cycle, model the IO buffer read delay, and retire any read response against the scoreboard.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         for (int k = 3; k > 0; k--) dl[i][k] = dl[i][k-1];
         dl[i][0]  = en_in[i] ? rd_val(ain[i]) : {8{32'hBAD0_0000 | cyc}};
         io_din[i] = dl[i][LAT[i]];
      end
      #1;
      if (rspv[sel] != 4'b0) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", {252'b0, rspv[sel]}, '0);
         end else begin
            e = sb.pop_front();
            chk("rsp_port", {252'b0, rspv[sel]}, DW'(1) << e.port);
            chk("rsp_data", rdata[sel], e.data);
            chk("rsp_cycle", DW'(cyc), DW'(e.cyc));
         end
      end
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] a0, a3;
      int            p;
      sel = 2'd0; cyc = 0; total = 0; passed = 0;
      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 3; i++) begin
         io_din[i] = '0;
         for (int k = 0; k < 4; k++) dl[i][k] = '0;
      end

      // Reset state
      step(); step();
      chk("rst_en_in",   {255'b0, en_in[0]}, '0);
      chk("rst_en_out",  {255'b0, en_out[0]}, '0);
      chk("rst_addr_out", {240'b0, aout[0]}, '0);
      chk("rst_data_out", dout[0], '0);
      chk("rst_rsp_valid", {252'b0, rspv[0]}, '0);
      chk("rst_rsp_rdata", rdata[0], '0);
      chk("rst_idle",    {255'b0, idle_o[0]}, 1);
      rst = 1'b0;
      step();

      // Single write from port 2
      req_valid = 4'b0100; req_we = 4'b0100;
      req_addr[2*AW +: AW] = 16'h0010;
      req_wdata[2*DW +: DW] = {32{8'hA5}};
      #1 chk("t1_grant", {252'b0, rdy[0]}, 4'b0100);
      step();
      req_valid = '0;
      #1;
      chk("t1_en_out",   {255'b0, en_out[0]}, 1);
      chk("t1_addr_out", {240'b0, aout[0]}, 16'h0010);
      chk("t1_data_out", dout[0], {32{8'hA5}});
      chk("t1_en_in",    {255'b0, en_in[0]}, 0);
      step();
      chk("t1_en_out_drop", {255'b0, en_out[0]}, 0);
      chk("t1_addr_held",   {240'b0, aout[0]}, 16'h0010);
      chk("t1_busy",        {255'b0, idle_o[0]}, 0);
      step();
      chk("t1_idle_back",   {255'b0, idle_o[0]}, 1);

      // Single read from port 1, latency 1
      req_valid = 4'b0010; req_we = '0;
      req_addr[1*AW +: AW] = 16'h0003;
      #1 chk("t2_grant", {252'b0, rdy[0]}, 4'b0010);
      sb.push_back('{port: 1, data: rd_val(16'h0003), cyc: cyc + 3});
      step();
      req_valid = '0;
      #1;
      chk("t2_en_in",   {255'b0, en_in[0]}, 1);
      chk("t2_addr_in", {240'b0, ain[0]}, 16'h0003);
      chk("t2_en_out",  {255'b0, en_out[0]}, 0);
      repeat (4) step();
      chk("t2_drained", DW'(sb.size()), '0);
      chk("t2_rdata_held", rdata[0], rd_val(16'h0003));

      // All four ports reading continuously
      do_reset();
      for (int q = 0; q < 4; q++) req_addr[q*AW +: AW] = 16'h0100 + 16'(q);
      req_we = '0; req_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         #1 chk("t3_grant", {252'b0, rdy[0]}, DW'(1) << (i % 4));
         sb.push_back('{port: i % 4, data: rd_val(16'h0100 + 16'(i % 4)), cyc: cyc + 3});
         step();
      end
      req_valid = '0;
      repeat (4) step();
      chk("t3_drained", DW'(sb.size()), '0);

      // Ports 0 and 3 alternating reads, latency 3
      do_reset();
      sel = 2'd1;
      a0 = 16'h0200; a3 = 16'h0300;
      req_addr[0 +: AW] = a0; req_addr[3*AW +: AW] = a3;
      req_we = '0; req_valid = 4'b1001;
      for (int i = 0; i < 6; i++) begin
         p = (i % 2 == 0) ? 0 : 3;
         #1 chk("t4_grant", {252'b0, rdy[1]}, DW'(1) << p);
         sb.push_back('{port: p, data: rd_val(p == 0 ? a0 : a3), cyc: cyc + 5});
         step();
         if (p == 0) begin a0 = a0 + 16'd1; req_addr[0 +: AW] = a0; end
         else        begin a3 = a3 + 16'd1; req_addr[3*AW +: AW] = a3; end
      end
      req_valid = '0;
      repeat (7) step();
      chk("t4_drained", DW'(sb.size()), '0);

      // Reset while a read is in flight
      req_valid = 4'b0100; req_we = '0;
      req_addr[2*AW +: AW] = 16'h0444;
      #1 chk("t5_grant", {252'b0, rdy[1]}, 4'b0100);
      step();
      req_valid = '0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1 chk("t5_no_rsp", {252'b0, rspv[1]}, '0);
         step();
      end
      chk("t5_idle", {255'b0, idle_o[1]}, 1);
      req_valid = 4'b0011; req_we = 4'b0011;
      #1 chk("t5_ptr_reset", {252'b0, rdy[1]}, 4'b0001);
      step();
      req_valid = '0;
      step();

      // Three-port instance, ports 0 and 2 contending
      do_reset();
      sel = 2'd2;
      req_we = 4'b0101; req_valid = 4'b0101;
      for (int i = 0; i < 6; i++) begin
         #1 chk("t6_grant", {252'b0, rdy[2]}, (i % 2 == 0) ? 4'b0001 : 4'b0100);
         step();
      end
      req_valid = '0;
      repeat (3) step();
      chk("t6_no_rsp_pending", DW'(sb.size()), '0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
